// File: rtl/icache.sv
// ---------------------------------------------------------------------------
// icache -- direct-mapped, one-word-per-line instruction cache
//
// Serves fetch requests from the fetch unit. A hit returns its word one cycle
// after the request. A miss hands a word-aligned address to the memory
// controller, waits for the returned word, fills the line, and forwards the
// word to the fetch unit. A branch-misprediction rollback discards an idle
// request at once. During an outstanding miss it lets the fill finish but
// suppresses delivery of the word.
//
// Parameters
//   LINES        number of lines (power of two, 2..256)
//
// Ports
//   clkIn        system clock, rising edge
//   rstIn        asynchronous active-low reset
//   rdyIn        global ready; low freezes every register
//   rollback     branch-misprediction flush
//   fetchValid   fetch unit presents fetchPC this cycle
//   fetchPC      PC to fetch (bits [1:0] ignored)
//   icReady      block is idle and accepts a request
//   instValid    one-cycle pulse, inst holds a delivered word
//   inst         delivered instruction word
//   iFlag        fetch request to the memory controller
//   iAddr        word-aligned miss address to the memory controller
//   iDone        memory controller finished; Loaded is valid
//   Loaded       word returned by the memory controller
//   hitCnt       accepted hits   (only with ICACHE_STAT_EN)
//   missCnt      accepted misses (only with ICACHE_STAT_EN)
//
// Optional feature macro: ICACHE_STAT_EN adds the hit/miss counters.
// ---------------------------------------------------------------------------
module icache #(
  parameter int LINES = 16
) (
  input  logic        clkIn,
  input  logic        rstIn,
  input  logic        rdyIn,
  input  logic        rollback,
  input  logic        fetchValid,
  input  logic [31:0] fetchPC,
  output logic        icReady,
  output logic        instValid,
  output logic [31:0] inst,
  output logic        iFlag,
  output logic [31:0] iAddr,
  input  logic        iDone,
  input  logic [31:0] Loaded
`ifdef ICACHE_STAT_EN
  ,
  output logic [31:0] hitCnt,
  output logic [31:0] missCnt
`endif
);

  localparam int IDX  = $clog2(LINES);
  localparam int TAGW = 30 - IDX;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MISS = 2'd1,
    KILL = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [LINES-1:0] valid_bits;
  logic [TAGW-1:0]  tag_mem  [LINES];
  logic [31:0]      data_mem [LINES];

  logic [IDX-1:0]  fetch_idx;
  logic [TAGW-1:0] fetch_tag;
  logic [IDX-1:0]  fill_idx;
  logic [TAGW-1:0] fill_tag;
  logic            hit;

  logic        inst_valid_next;
  logic [31:0] inst_next;
  logic        iflag_next;
  logic [31:0] iaddr_next;
  logic        fill_en;
  logic        hit_evt;
  logic        miss_evt;

  // The byte-offset bits carry no information for a word cache.
  logic unused_bits;
  assign unused_bits = ^{fetchPC[1:0], iAddr[1:0], hit_evt, miss_evt};

  // The pending miss address doubles as the latched PC, so the fill
  // index and tag come from iAddr rather than from a separate register.
  assign fetch_idx = fetchPC[IDX+1:2];
  assign fetch_tag = fetchPC[31:IDX+2];
  assign fill_idx  = iAddr[IDX+1:2];
  assign fill_tag  = iAddr[31:IDX+2];
  assign hit       = valid_bits[fetch_idx] && (tag_mem[fetch_idx] == fetch_tag);

  assign icReady = (state == IDLE);

  // Next-state and next-output logic. When rdyIn is low, everything keeps
  // its value and the inputs are not looked at. A rollback that arrives in
  // the same cycle as iDone during MISS is treated like a kill: the line is
  // still filled, but the stale word is not delivered.
  always_comb begin
    state_next      = state;
    inst_valid_next = 1'b0;
    inst_next       = inst;
    iflag_next      = iFlag;
    iaddr_next      = iAddr;
    fill_en         = 1'b0;
    hit_evt         = 1'b0;
    miss_evt        = 1'b0;

    if (!rdyIn) begin
      inst_valid_next = instValid;
    end else begin
      case (state)
        IDLE: begin
          if (rollback) begin
            state_next = IDLE;
          end else if (fetchValid) begin
            if (hit) begin
              inst_valid_next = 1'b1;
              inst_next       = data_mem[fetch_idx];
              hit_evt         = 1'b1;
            end else begin
              iflag_next = 1'b1;
              iaddr_next = {fetchPC[31:2], 2'b00};
              state_next = MISS;
              miss_evt   = 1'b1;
            end
          end
        end
        MISS: begin
          if (iDone) begin
            fill_en    = 1'b1;
            iflag_next = 1'b0;
            state_next = IDLE;
            if (!rollback) begin
              inst_valid_next = 1'b1;
              inst_next       = Loaded;
            end
          end else if (rollback) begin
            state_next = KILL;
          end
        end
        KILL: begin
          if (iDone) begin
            fill_en    = 1'b1;
            iflag_next = 1'b0;
            state_next = IDLE;
          end
        end
        default: begin
          state_next = IDLE;
          iflag_next = 1'b0;
        end
      endcase
    end
  end

  // State and control registers, plus the valid bits. Reset drops any
  // outstanding fetch, so an iDone that arrives after it lands in IDLE
  // and is ignored.
  always_ff @(posedge clkIn or negedge rstIn) begin
    if (!rstIn) begin
      state      <= IDLE;
      instValid  <= 1'b0;
      inst       <= 32'd0;
      iFlag      <= 1'b0;
      iAddr      <= 32'd0;
      valid_bits <= '0;
    end else begin
      state     <= state_next;
      instValid <= inst_valid_next;
      inst      <= inst_next;
      iFlag     <= iflag_next;
      iAddr     <= iaddr_next;
      if (fill_en) begin
        valid_bits[fill_idx] <= 1'b1;
      end
    end
  end

  // Tag and data storage. These need no reset because the valid bits gate
  // every use of them. A fill overwrites whatever the line held before.
  always_ff @(posedge clkIn) begin
    if (fill_en) begin
      tag_mem[fill_idx]  <= fill_tag;
      data_mem[fill_idx] <= Loaded;
    end
  end

`ifdef ICACHE_STAT_EN
  // Free-running statistics counters. They count only accepted requests,
  // so requests that are frozen, rolled back, or ignored are not counted.
  always_ff @(posedge clkIn or negedge rstIn) begin
    if (!rstIn) begin
      hitCnt  <= 32'd0;
      missCnt <= 32'd0;
    end else begin
      if (hit_evt) begin
        hitCnt <= hitCnt + 32'd1;
      end
      if (miss_evt) begin
        missCnt <= missCnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_icache.sv
// ---------------------------------------------------------------------------
// tb_icache -- self-checking bench for icache (LINES = 16)
//
// A table of per-cycle vectors drives the main behaviour: cold miss, hit,
// conflict eviction, rollback in IDLE and MISS, and the rdyIn freeze.
// Hand-written sequences cover reset, the asynchronous reset during a miss,
// and an iDone that arrives after that reset.
// ---------------------------------------------------------------------------
module tb_icache;

  logic        clkIn;
  logic        rstIn;
  logic        rdyIn;
  logic        rollback;
  logic        fetchValid;
  logic [31:0] fetchPC;
  logic        icReady;
  logic        instValid;
  logic [31:0] inst;
  logic        iFlag;
  logic [31:0] iAddr;
  logic        iDone;
  logic [31:0] Loaded;
`ifdef ICACHE_STAT_EN
  logic [31:0] hitCnt;
  logic [31:0] missCnt;
`endif

  int errors;
  int checks;

  typedef struct {
    string       name;
    logic        rdy;
    logic        rb;
    logic        fv;
    logic [31:0] pc;
    logic        done;
    logic [31:0] ld;
    logic        eReady;
    logic        eValid;
    logic [31:0] eInst;
    logic        eFlag;
    logic [31:0] eAddr;
  } vec_t;

  vec_t vecs[$];

  icache #(.LINES(16)) dut (
    .clkIn      (clkIn),
    .rstIn      (rstIn),
    .rdyIn      (rdyIn),
    .rollback   (rollback),
    .fetchValid (fetchValid),
    .fetchPC    (fetchPC),
    .icReady    (icReady),
    .instValid  (instValid),
    .inst       (inst),
    .iFlag      (iFlag),
    .iAddr      (iAddr),
    .iDone      (iDone),
    .Loaded     (Loaded)
`ifdef ICACHE_STAT_EN
    ,
    .hitCnt     (hitCnt),
    .missCnt    (missCnt)
`endif
  );

  // 10 ns clock period.
  initial clkIn = 1'b0;
  always #5 clkIn = ~clkIn;

  // Compares one value against its expected value and keeps the tallies.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Builds one table row.
  function automatic vec_t mk(input string name, input logic rdy, input logic rb, input logic fv,
                              input logic [31:0] pc, input logic done, input logic [31:0] ld,
                              input logic eReady, input logic eValid, input logic [31:0] eInst,
                              input logic eFlag, input logic [31:0] eAddr);
    vec_t v;
    v.name = name; v.rdy = rdy; v.rb = rb; v.fv = fv; v.pc = pc; v.done = done; v.ld = ld;
    v.eReady = eReady; v.eValid = eValid; v.eInst = eInst; v.eFlag = eFlag; v.eAddr = eAddr;
    return v;
  endfunction

  // Drives one vector on the falling edge, then samples 1 ns after the
  // next rising edge. inst is checked only when a word is expected, and
  // iAddr only while a request is expected to be outstanding.
  task automatic applyStimulus(input vec_t v);
    @(negedge clkIn);
    rdyIn      = v.rdy;
    rollback   = v.rb;
    fetchValid = v.fv;
    fetchPC    = v.pc;
    iDone      = v.done;
    Loaded     = v.ld;
    @(posedge clkIn);
    #1;
    checkOutput({v.name, ".icReady"},   {31'd0, icReady},   {31'd0, v.eReady});
    checkOutput({v.name, ".instValid"}, {31'd0, instValid}, {31'd0, v.eValid});
    checkOutput({v.name, ".iFlag"},     {31'd0, iFlag},     {31'd0, v.eFlag});
    if (v.eValid) checkOutput({v.name, ".inst"}, inst, v.eInst);
    if (v.eFlag)  checkOutput({v.name, ".iAddr"}, iAddr, v.eAddr);
  endtask

  task automatic idleInputs();
    rdyIn      = 1'b1;
    rollback   = 1'b0;
    fetchValid = 1'b0;
    fetchPC    = 32'd0;
    iDone      = 1'b0;
    Loaded     = 32'd0;
  endtask

  initial begin
    errors = 0;
    checks = 0;

    //            name        rdy rb fv pc            done ld            rdy val inst          flg addr
    vecs.push_back(mk("cold",     1, 0, 1, 32'h00001000, 0, 32'h0,        0, 0, 32'h0,        1, 32'h00001000));
    vecs.push_back(mk("ignfv",    1, 0, 1, 32'h00002000, 0, 32'h0,        0, 0, 32'h0,        1, 32'h00001000));
    vecs.push_back(mk("fill1",    1, 0, 0, 32'h0,        1, 32'h00000013, 1, 1, 32'h00000013, 0, 32'h0));
    vecs.push_back(mk("pulse",    1, 0, 0, 32'h0,        0, 32'h0,        1, 0, 32'h0,        0, 32'h0));
    vecs.push_back(mk("hit1",     1, 0, 1, 32'h00001002, 0, 32'h0,        1, 1, 32'h00000013, 0, 32'h0));
    vecs.push_back(mk("confl",    1, 0, 1, 32'h00001040, 0, 32'h0,        0, 0, 32'h0,        1, 32'h00001040));
    vecs.push_back(mk("fill2",    1, 0, 0, 32'h0,        1, 32'hAAAA5555, 1, 1, 32'hAAAA5555, 0, 32'h0));
    vecs.push_back(mk("evict",    1, 0, 1, 32'h00001000, 0, 32'h0,        0, 0, 32'h0,        1, 32'h00001000));
    vecs.push_back(mk("fill3",    1, 0, 0, 32'h0,        1, 32'h00000013, 1, 1, 32'h00000013, 0, 32'h0));
    vecs.push_back(mk("rbdrop",   1, 1, 1, 32'h00001004, 0, 32'h0,        1, 0, 32'h0,        0, 32'h0));
    vecs.push_back(mk("miss4",    1, 0, 1, 32'h00001004, 0, 32'h0,        0, 0, 32'h0,        1, 32'h00001004));
    vecs.push_back(mk("kill",     1, 1, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        1, 32'h00001004));
    vecs.push_back(mk("kill2",    1, 1, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        1, 32'h00001004));
    vecs.push_back(mk("killfill", 1, 0, 0, 32'h0,        1, 32'hDEADBEEF, 1, 0, 32'h0,        0, 32'h0));
    vecs.push_back(mk("hitkill",  1, 0, 1, 32'h00001004, 0, 32'h0,        1, 1, 32'hDEADBEEF, 0, 32'h0));
    vecs.push_back(mk("miss8",    1, 0, 1, 32'h00001008, 0, 32'h0,        0, 0, 32'h0,        1, 32'h00001008));
    vecs.push_back(mk("frz1",     0, 0, 0, 32'h0,        1, 32'h11111111, 0, 0, 32'h0,        1, 32'h00001008));
    vecs.push_back(mk("frz2",     0, 1, 0, 32'h0,        1, 32'h11111111, 0, 0, 32'h0,        1, 32'h00001008));
    vecs.push_back(mk("frz3",     0, 0, 0, 32'h0,        1, 32'h11111111, 0, 0, 32'h0,        1, 32'h00001008));
    vecs.push_back(mk("thaw",     1, 0, 0, 32'h0,        1, 32'h22222222, 1, 1, 32'h22222222, 0, 32'h0));
    vecs.push_back(mk("hit8",     1, 0, 1, 32'h00001008, 0, 32'h0,        1, 1, 32'h22222222, 0, 32'h0));
    vecs.push_back(mk("quiet",    1, 0, 0, 32'h0,        0, 32'h0,        1, 0, 32'h0,        0, 32'h0));

    // Reset state, sampled while reset is held across clock edges.
    idleInputs();
    rstIn = 1'b0;
    repeat (2) @(posedge clkIn);
    #1;
    checkOutput("rst.icReady",   {31'd0, icReady},   32'd1);
    checkOutput("rst.instValid", {31'd0, instValid}, 32'd0);
    checkOutput("rst.inst",      inst,               32'd0);
    checkOutput("rst.iFlag",     {31'd0, iFlag},     32'd0);
    checkOutput("rst.iAddr",     iAddr,              32'd0);
`ifdef ICACHE_STAT_EN
    checkOutput("rst.hitCnt",  hitCnt,  32'd0);
    checkOutput("rst.missCnt", missCnt, 32'd0);
`endif
    @(negedge clkIn);
    rstIn = 1'b1;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
    end

`ifdef ICACHE_STAT_EN
    // Accepted hits: hit1, hitkill, hit8. Accepted misses: cold, confl, evict, miss4, miss8.
    checkOutput("stat.hitCnt",  hitCnt,  32'd3);
    checkOutput("stat.missCnt", missCnt, 32'd5);
`endif

    // Start a miss, then assert reset between clock edges.
    applyStimulus(mk("premiss", 1, 0, 1, 32'h00002000, 0, 32'h0, 0, 0, 32'h0, 1, 32'h00002000));
    @(negedge clkIn);
    idleInputs();
    #2;
    rstIn = 1'b0;
    #1;
    checkOutput("arst.iFlag",     {31'd0, iFlag},     32'd0);
    checkOutput("arst.icReady",   {31'd0, icReady},   32'd1);
    checkOutput("arst.instValid", {31'd0, instValid}, 32'd0);
`ifdef ICACHE_STAT_EN
    checkOutput("arst.hitCnt",  hitCnt,  32'd0);
    checkOutput("arst.missCnt", missCnt, 32'd0);
`endif
    @(negedge clkIn);
    rstIn = 1'b1;

    // The abandoned fetch's iDone arrives late and must be ignored.
    applyStimulus(mk("lateDone", 1, 0, 0, 32'h0, 1, 32'h55555555, 1, 0, 32'h0, 0, 32'h0));
    // A PC that was filled before the reset now misses.
    applyStimulus(mk("postrst",  1, 0, 1, 32'h00001000, 0, 32'h0, 0, 0, 32'h0, 1, 32'h00001000));
    applyStimulus(mk("postfill", 1, 0, 0, 32'h0, 1, 32'h00000077, 1, 1, 32'h00000077, 0, 32'h0));
`ifdef ICACHE_STAT_EN
    checkOutput("post.missCnt", missCnt, 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
